// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, 2N-bit dividend by N-bit divisor
module restoring_divider #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic [2*N-1:0] data_out,
   output logic           div_by_zero,
   output logic           overflow,
   output logic           busy,
   output logic           done
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      SUB,
      DONE
   } state_t;

   state_t        state;
   logic [N:0]    a;
   logic [N-1:0]  q;
   logic [N-1:0]  m;
   logic [CW-1:0] count;
   logic [N:0]    trial;

   // A is one bit wider than M, so trial[N] is the borrow of the subtraction
   assign trial    = a - {1'b0, m};
   assign data_out = {remainder, quotient};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a           <= '0;
         q           <= '0;
         m           <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               a     <= {1'b0, dividend[2*N-1:N]};
               q     <= dividend[N-1:0];
               m     <= divisor;
               count <= CW'(N);
               if (divisor == '0) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  quotient    <= '1;
                  remainder   <= '0;
                  div_by_zero <= 1'b1;
                  overflow    <= 1'b0;
               end else if (dividend[2*N-1:N] >= divisor) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  quotient    <= '1;
                  remainder   <= '0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b1;
               end else begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               {a, q} <= {a[N-1:0], q, 1'b0};
               state  <= SUB;
            end
            SUB: begin
               count <= count - 1'b1;
               if (!trial[N]) begin
                  a    <= trial;
                  q[0] <= 1'b1;
               end
               // Last iteration: capture the result as it is being formed
               if (count == CW'(1)) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  quotient    <= trial[N] ? q : {q[N-1:1], 1'b1};
                  remainder   <= trial[N] ? a[N-1:0] : trial[N-1:0];
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
               end else begin
                  state <= SHIFT;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - directed self-checking bench for restoring_divider
module tb_restoring_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic [7:0] data_out;
   logic       div_by_zero;
   logic       overflow;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_err = 0;

   restoring_divider #(.N(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .quotient   (quotient),
      .remainder  (remainder),
      .data_out   (data_out),
      .div_by_zero(div_by_zero),
      .overflow   (overflow),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives operands, lets start be sampled at edge 0, returns in cycle 1
   task automatic launch(input logic [7:0] dvd, input logic [3:0] dvs, input bit hold);
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      step();
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit busy_all);
      cyc      = 1;
      busy_all = 1'b1;
      while (done !== 1'b1 && cyc < 30) begin
         if (busy !== 1'b1) busy_all = 1'b0;
         step();
         cyc++;
      end
      if (busy !== 1'b1) busy_all = 1'b0;
   endtask

   initial begin
      int cyc;
      bit busy_all;
      int ndone;
      int dcyc;
      logic [7:0] dat;

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      step(); step(); step();
      rst = 1'b0;
      check("reset_data_out", {8'h0, data_out}, 16'h0000);
      check("reset_flags", {12'h0, div_by_zero, overflow, busy, done}, 16'h0000);

      // 100 / 7 = 14 r 2
      launch(8'h64, 4'h7, 1'b0);
      wait_done(cyc, busy_all);
      check("div100_7_cycle", 16'(cyc), 16'd10);
      check("div100_7_busy", {15'h0, busy_all}, 16'h0001);
      check("div100_7_data", {8'h0, data_out}, 16'h002E);
      check("div100_7_qr", {8'h0, quotient, remainder}, 16'h00E2);
      check("div100_7_flags", {14'h0, div_by_zero, overflow}, 16'h0000);
      step();
      check("div100_7_idle", {14'h0, busy, done}, 16'h0000);

      // 225 / 15 then 119 / 15 with start held high
      launch(8'hE1, 4'hF, 1'b1);
      wait_done(cyc, busy_all);
      check("div225_15_cycle", 16'(cyc), 16'd10);
      check("div225_15_data", {8'h0, data_out}, 16'h000F);
      dividend = 8'h77;
      step();
      check("held_idle_busy", {15'h0, busy}, 16'h0000);
      step();
      start = 1'b0;
      wait_done(cyc, busy_all);
      check("div119_15_cycle", 16'(cyc), 16'd10);
      check("div119_15_data", {8'h0, data_out}, 16'h00E7);
      step();

      // divide by zero, then a clean 0 / 5
      launch(8'h12, 4'h0, 1'b0);
      wait_done(cyc, busy_all);
      check("dbz_cycle", 16'(cyc), 16'd2);
      check("dbz_flags", {14'h0, div_by_zero, overflow}, 16'h0002);
      check("dbz_qr", {8'h0, quotient, remainder}, 16'h00F0);
      step();
      launch(8'h00, 4'h5, 1'b0);
      wait_done(cyc, busy_all);
      check("div0_5_data", {8'h0, data_out}, 16'h0000);
      check("div0_5_flags", {14'h0, div_by_zero, overflow}, 16'h0000);
      step();

      // overflow, then 47 / 3 = 15 r 2
      launch(8'h50, 4'h3, 1'b0);
      wait_done(cyc, busy_all);
      check("ovf_cycle", 16'(cyc), 16'd2);
      check("ovf_flags", {14'h0, div_by_zero, overflow}, 16'h0001);
      check("ovf_quotient", {12'h0, quotient}, 16'h000F);
      step();
      launch(8'h2F, 4'h3, 1'b0);
      wait_done(cyc, busy_all);
      check("div47_3_data", {8'h0, data_out}, 16'h002F);
      check("div47_3_flags", {14'h0, div_by_zero, overflow}, 16'h0000);
      step();

      // start pulses while busy are ignored
      launch(8'h64, 4'h7, 1'b0);
      ndone = 0; dcyc = 0; dat = '0;
      for (int c = 1; c <= 14; c++) begin
         start = (c == 3 || c == 7);
         if (done === 1'b1) begin
            ndone++;
            dcyc = c;
            dat  = data_out;
         end
         step();
      end
      start = 1'b0;
      check("ignore_start_ndone", 16'(ndone), 16'd1);
      check("ignore_start_cycle", 16'(dcyc), 16'd10);
      check("ignore_start_data", {8'h0, dat}, 16'h002E);
      check("ignore_start_idle", {15'h0, busy}, 16'h0000);

      // reset in cycle 5 aborts the operation
      launch(8'h64, 4'h7, 1'b0);
      step(); step(); step(); step();
      rst = 1'b1;
      step();
      check("abort_outputs", {8'h0, data_out}, 16'h0000);
      check("abort_flags", {12'h0, div_by_zero, overflow, busy, done}, 16'h0000);
      rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         if (done === 1'b1) ndone++;
         step();
      end
      check("abort_no_done", 16'(ndone), 16'd0);
      launch(8'h64, 4'h7, 1'b0);
      wait_done(cyc, busy_all);
      check("after_abort_cycle", 16'(cyc), 16'd10);
      check("after_abort_data", {8'h0, data_out}, 16'h002E);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
